pixel_bounce_render: RTL and testbench

Pixel-generation stage directly downstream of the display timing counter. Consumes the raw `hcount`/`vcount`/`hsync`/`vsync` stream and draws a bouncing square sprite over a bordered background. It emits one registered 12-bit RGB pixel per clock, with sync delayed to match. Sprite position and colour update once per frame, during vertical front porch.

---
 rtl/pixel_bounce_render.sv | 160 ++++++++++++++++
 tb/tb_pixel_bounce_render.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pixel_bounce_render.sv
// rtl/pixel_bounce_render.sv - bouncing square sprite over a bordered background, one registered RGB pixel per clock
module pixel_bounce_render #(
  parameter int          H_START = 144,
  parameter int          V_START = 31,
  parameter int          H_VIS   = 640,
  parameter int          V_VIS   = 480,
  parameter int          SIZE    = 32,
  parameter int          SPEED   = 2,
  parameter int          INIT_X  = 304,
  parameter int          INIT_Y  = 224,
  parameter logic [11:0] BG_RGB  = 12'h002
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        run,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [10:0] H_BEG11  = 11'(H_START);
  localparam logic [10:0] H_END11  = 11'(H_START + H_VIS);
  localparam logic [10:0] V_BEG11  = 11'(V_START);
  localparam logic [10:0] V_END11  = 11'(V_START + V_VIS);
  localparam logic [10:0] H_VIS11  = 11'(H_VIS);
  localparam logic [10:0] V_VIS11  = 11'(V_VIS);
  localparam logic [10:0] SIZE11   = 11'(SIZE);
  localparam logic [10:0] SPEED11  = 11'(SPEED);
  localparam logic [9:0]  X_MAX    = 10'(H_VIS - SIZE);
  localparam logic [9:0]  Y_MAX    = 10'(V_VIS - SIZE);
  localparam logic [9:0]  TICK_V   = 10'(V_START + V_VIS);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  xpos_q, xpos_d, ypos_q, ypos_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [2:0]  cidx_q, cidx_d;
  logic        fired_q, fired_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q;

  logic [9:0]  x, y;
  logic [10:0] x11, y11, xp11, yp11;
  logic        visible, hit, border, tick_line, tick_cond, tick;
  logic        flip_x, flip_y;
  logic [11:0] pal;

  assign x    = hcount - H_BEG11[9:0];
  assign y    = vcount - V_BEG11[9:0];
  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign xp11 = {1'b0, xpos_q};
  assign yp11 = {1'b0, ypos_q};

  assign visible = ({1'b0, hcount} >= H_BEG11) && ({1'b0, hcount} < H_END11) &&
                   ({1'b0, vcount} >= V_BEG11) && ({1'b0, vcount} < V_END11);
  assign hit     = (x11 >= xp11) && (x11 < xp11 + SIZE11) &&
                   (y11 >= yp11) && (y11 < yp11 + SIZE11);
  assign border  = (x11 == 11'd0) || (x11 == H_VIS11 - 11'd1) ||
                   (y11 == 11'd0) || (y11 == V_VIS11 - 11'd1);

  // fired_q blocks a second tick if hcount lingers at 0 on the front-porch line
  assign tick_line = (vcount == TICK_V);
  assign tick_cond = tick_line && (hcount == 10'd0);
  assign tick      = tick_cond && !fired_q;
  assign fired_d   = tick_line ? (fired_q | tick_cond) : 1'b0;

  always_comb begin
    pal = 12'hF00;
    case (cidx_q)
      3'd0: pal = 12'hF00;
      3'd1: pal = 12'h0F0;
      3'd2: pal = 12'h00F;
      3'd3: pal = 12'hFF0;
      3'd4: pal = 12'h0FF;
      3'd5: pal = 12'hF0F;
      3'd6: pal = 12'hFFF;
      3'd7: pal = 12'hF80;
      default: pal = 12'hF00;
    endcase
    if (!visible)    rgb_d = 12'h000;
    else if (hit)    rgb_d = pal;
    else if (border) rgb_d = 12'hFFF;
    else             rgb_d = BG_RGB;
  end

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cidx_d  = cidx_q;
    flip_x  = 1'b0;
    flip_y  = 1'b0;
    case (state_q)
      IDLE: if (tick && run) state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        if (!dx_q) begin
          if (xp11 + SIZE11 + SPEED11 > H_VIS11) begin
            xpos_d = X_MAX; dx_d = 1'b1; flip_x = 1'b1;
          end else xpos_d = xpos_q + SPEED11[9:0];
        end else begin
          if (xp11 < SPEED11) begin
            xpos_d = 10'd0; dx_d = 1'b0; flip_x = 1'b1;
          end else xpos_d = xpos_q - SPEED11[9:0];
        end
        if (!dy_q) begin
          if (yp11 + SIZE11 + SPEED11 > V_VIS11) begin
            ypos_d = Y_MAX; dy_d = 1'b1; flip_y = 1'b1;
          end else ypos_d = ypos_q + SPEED11[9:0];
        end else begin
          if (yp11 < SPEED11) begin
            ypos_d = 10'd0; dy_d = 1'b0; flip_y = 1'b1;
          end else ypos_d = ypos_q - SPEED11[9:0];
        end
        // a corner bounce flips both axes but advances the colour only once
        if (flip_x || flip_y) cidx_d = cidx_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xpos_q  <= 10'(INIT_X);
      ypos_q  <= 10'(INIT_Y);
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      cidx_q  <= 3'd0;
      fired_q <= 1'b0;
      rgb_q   <= 12'h000;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cidx_q  <= cidx_d;
      fired_q <= fired_d;
      rgb_q   <= rgb_d;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule

// File: tb/tb_pixel_bounce_render.sv
// tb/tb_pixel_bounce_render.sv - directed scoreboard bench for pixel_bounce_render
module tb_pixel_bounce_render;

  logic        clk_25MHz = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        hsync_in, vsync_in, run;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int failures = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  int xm, ym, cm;
  bit dxm, dym;

  pixel_bounce_render dut (
    .clk_25MHz(clk_25MHz), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .run(run),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #10 clk_25MHz = ~clk_25MHz;

  task automatic cmp(string tag, logic [13:0] obs, logic [13:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] pal(int c);
    case (c)
      0: return 12'hF00; 1: return 12'h0F0; 2: return 12'h00F; 3: return 12'hFF0;
      4: return 12'h0FF; 5: return 12'hF0F; 6: return 12'hFFF; default: return 12'hF80;
    endcase
  endfunction

  function automatic logic [11:0] model_px(int h, int v);
    int x, y;
    if (h < 144 || h >= 784 || v < 31 || v >= 511) return 12'h000;
    x = h - 144; y = v - 31;
    if (x >= xm && x < xm + 32 && y >= ym && y < ym + 32) return pal(cm);
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
    return 12'h002;
  endfunction

  task automatic model_reset();
    xm = 304; ym = 224; dxm = 0; dym = 0; cm = 0;
  endtask

  // One clock: drive inputs, queue the expectation, then scramble inputs before
  // comparing so a combinational path to the outputs cannot pass.
  task automatic drive_px(int h, int v, logic hs, logic vs, logic [11:0] e, string tag);
    logic [13:0] expv, obs;
    hcount = h[9:0]; vcount = v[9:0]; hsync_in = hs; vsync_in = vs;
    exp_q.push_back({e, hs, vs}); tag_q.push_back(tag);
    @(posedge clk_25MHz); #1;
    hsync_in = ~hs; vsync_in = ~vs; hcount = 10'd0; vcount = 10'd0;
    #1;
    obs = {rgb, hsync_out, vsync_out};
    expv = exp_q.pop_front();
    cmp(tag_q.pop_front(), obs, expv);
  endtask

  task automatic pxm(int h, int v, string tag);
    drive_px(h, v, 1'b0, 1'b0, model_px(h, v), tag);
  endtask

  task automatic do_tick(bit r, output bit both);
    bit fx, fy;
    fx = 0; fy = 0;
    run = r;
    drive_px(0, 511, 1'b0, 1'b1, 12'h000, "tick");
    run = ~r;
    if (r) begin
      if (!dxm) begin
        if (xm + 34 > 640) begin xm = 608; dxm = 1; fx = 1; end else xm += 2;
      end else begin
        if (xm < 2) begin xm = 0; dxm = 0; fx = 1; end else xm -= 2;
      end
      if (!dym) begin
        if (ym + 34 > 480) begin ym = 448; dym = 1; fy = 1; end else ym += 2;
      end else begin
        if (ym < 2) begin ym = 0; dym = 0; fy = 1; end else ym -= 2;
      end
      if (fx || fy) cm = (cm + 1) % 8;
    end
    both = fx && fy;
    drive_px(1, 511, 1'b0, 1'b1, 12'h000, "update_blank");
    drive_px(5, 0, 1'b1, 1'b0, 12'h000, "rearm");
    run = 1'b0;
  endtask

  initial begin
    bit both;
    int t;
    rst = 1'b1; hcount = 10'd300; vcount = 10'd100; hsync_in = 1'b1; vsync_in = 1'b1; run = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_25MHz);
    #1;
    cmp("reset_out", {rgb, hsync_out, vsync_out}, 14'h0);
    rst = 1'b0;

    drive_px(144, 31, 1'b1, 1'b0, 12'hFFF, "border_tl");
    drive_px(145, 32, 1'b0, 1'b1, 12'h002, "background");
    drive_px(448, 255, 1'b1, 1'b1, 12'hF00, "sprite_tl");
    drive_px(479, 286, 1'b0, 1'b0, 12'hF00, "sprite_br");
    drive_px(480, 286, 1'b0, 1'b0, 12'h002, "sprite_right_edge");
    drive_px(100, 100, 1'b1, 1'b0, 12'h000, "blank");
    drive_px(783, 510, 1'b0, 1'b0, 12'hFFF, "border_br");
    drive_px(784, 200, 1'b0, 1'b0, 12'h000, "blank_right");

    drive_px(448, 255, 1'b1, 1'b1, 12'hF00, "pre_reset");
    #3 rst = 1'b1;
    #1 cmp("async_reset", {rgb, hsync_out, vsync_out}, 14'h0);
    @(posedge clk_25MHz); #5 rst = 1'b0;
    model_reset();
    drive_px(448, 255, 1'b0, 1'b0, 12'hF00, "post_reset_sprite");

    do_tick(1'b1, both);
    drive_px(450, 257, 1'b0, 1'b0, 12'hF00, "move1_tl");
    drive_px(449, 257, 1'b0, 1'b0, 12'h002, "move1_left");
    drive_px(481, 288, 1'b0, 1'b0, 12'hF00, "move1_br");
    for (int i = 0; i < 5; i++) do_tick(1'b0, both);
    drive_px(450, 257, 1'b0, 1'b0, 12'hF00, "frozen_tl");
    drive_px(449, 257, 1'b0, 1'b0, 12'h002, "frozen_left");
    drive_px(450, 256, 1'b0, 1'b0, 12'h002, "frozen_above");

    for (t = 2; t <= 112; t++) do_tick(1'b1, both);
    drive_px(144 + 528, 31 + 448, 1'b0, 1'b0, 12'hF00, "t112_tl");
    drive_px(144 + 528, 31 + 447, 1'b0, 1'b0, 12'h002, "t112_above");
    do_tick(1'b1, both);
    drive_px(144 + 530, 31 + 448, 1'b0, 1'b0, 12'h0F0, "t113_tl");
    drive_px(144 + 530, 31 + 479, 1'b0, 1'b0, 12'h0F0, "t113_bottom_row");
    do_tick(1'b1, both);
    drive_px(144 + 532, 31 + 446, 1'b0, 1'b0, 12'h0F0, "t114_tl");
    drive_px(144 + 532, 31 + 478, 1'b0, 1'b0, 12'h002, "t114_below");

    for (t = 115; t <= 152; t++) do_tick(1'b1, both);
    drive_px(144 + 608, 31 + 370, 1'b0, 1'b0, 12'h0F0, "t152_tl");
    do_tick(1'b1, both);
    drive_px(144 + 608, 31 + 368, 1'b0, 1'b0, 12'h00F, "t153_tl");
    drive_px(144 + 639, 31 + 368, 1'b0, 1'b0, 12'h00F, "t153_right_col");
    do_tick(1'b1, both);
    drive_px(144 + 606, 31 + 366, 1'b0, 1'b0, 12'h00F, "t154_tl");
    drive_px(144 + 638, 31 + 366, 1'b0, 1'b0, 12'h002, "t154_right");

    both = 0;
    for (t = 155; t < 8000 && !both; t++) begin
      do_tick(1'b1, both);
      pxm(144 + xm, 31 + ym, "track_tl");
      pxm(144 + xm + 31, 31 + ym + 31, "track_br");
    end
    cmp("corner_reached", {13'd0, both}, 14'd1);
    pxm(144 + xm + 5, 31 + ym + 5, "corner_colour");
    pxm(144 + xm + 32, 31 + ym, "corner_outside");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
